// File: rtl/icache_dm.sv
// Direct-mapped instruction cache between fetch and a word-per-beat refill port.
// Latency: hit response 1 cycle after accept; miss response WORDS beats + 2 cycles after accept.
// Backpressure: cpu_ready low outside IDLE and while a flush is taken; mem_req/mem_addr held until mem_ready.
module icache_dm #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LINES  = 16,
    parameter int WORDS  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_valid,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              flush,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);
    localparam int WB    = $clog2(WORDS);
    localparam int IB    = $clog2(LINES);
    localparam int OFF   = WB + 2;
    localparam int TAG_W = ADDR_W - OFF - IB;

    typedef enum logic [1:0] {S_IDLE, S_REFILL, S_RESPOND} state_t;

    state_t                       state_q, state_d;
    logic [LINES-1:0]             valid_q, valid_d;
    logic [LINES-1:0][TAG_W-1:0]  tag_q, tag_d;
    logic [DATA_W-1:0]            data_q [LINES][WORDS];
    logic [TAG_W-1:0]             req_tag_q, req_tag_d;
    logic [IB-1:0]                req_idx_q, req_idx_d;
    logic [WB-1:0]                req_word_q, req_word_d;
    logic [WB-1:0]                beat_q, beat_d;
    logic                         flush_pend_q, flush_pend_d;
    logic                         resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]            resp_data_q, resp_data_d;
    logic                         mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]            mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0]             hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]             miss_cnt_q, miss_cnt_d;

    logic                         dat_we;
    logic [WB-1:0]                a_word;
    logic [IB-1:0]                a_idx;
    logic [TAG_W-1:0]             a_tag;
    logic                         accept;
    logic                         hit;
    logic [1:0]                   unused_addr;

    assign a_word      = cpu_addr[OFF-1:2];
    assign a_idx       = cpu_addr[OFF+IB-1:OFF];
    assign a_tag       = cpu_addr[ADDR_W-1:OFF+IB];
    assign unused_addr = cpu_addr[1:0];

    // A flush (new or deferred) in IDLE takes the cycle, so no request is accepted alongside it.
    assign cpu_ready = !rst && (state_q == S_IDLE) && !flush && !flush_pend_q;
    assign accept    = cpu_valid && cpu_ready;
    assign hit       = valid_q[a_idx] && (tag_q[a_idx] == a_tag);

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

    // Next-state logic for lookup, refill sequencing, flush and counters.
    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        tag_d        = tag_q;
        req_tag_d    = req_tag_q;
        req_idx_d    = req_idx_q;
        req_word_d   = req_word_q;
        beat_d       = beat_q;
        flush_pend_d = flush_pend_q;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        dat_we       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (flush || flush_pend_q) begin
                    valid_d      = '0;
                    flush_pend_d = 1'b0;
                end else if (accept) begin
                    if (hit) begin
                        resp_valid_d = 1'b1;
                        resp_data_d  = data_q[a_idx][a_word];
                        if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_W'(1);
                    end else begin
                        req_tag_d  = a_tag;
                        req_idx_d  = a_idx;
                        req_word_d = a_word;
                        beat_d     = '0;
                        mem_req_d  = 1'b1;
                        mem_addr_d = {a_tag, a_idx, {WB{1'b0}}, 2'b00};
                        if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
                        state_d    = S_REFILL;
                    end
                end
            end
            S_REFILL: begin
                if (flush) flush_pend_d = 1'b1;
                if (mem_ready) begin
                    dat_we = 1'b1;
                    beat_d = beat_q + WB'(1);
                    if (beat_q == WB'(WORDS - 1)) begin
                        valid_d[req_idx_q] = 1'b1;
                        tag_d[req_idx_q]   = req_tag_q;
                        mem_req_d          = 1'b0;
                        state_d            = S_RESPOND;
                    end else begin
                        mem_addr_d = {req_tag_q, req_idx_q, beat_q + WB'(1), 2'b00};
                    end
                end
            end
            S_RESPOND: begin
                if (flush) flush_pend_d = 1'b1;
                resp_valid_d = 1'b1;
                resp_data_d  = data_q[req_idx_q][req_word_q];
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state, tags and counters; reset abandons any refill in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            valid_q      <= '0;
            tag_q        <= '0;
            req_tag_q    <= '0;
            req_idx_q    <= '0;
            req_word_q   <= '0;
            beat_q       <= '0;
            flush_pend_q <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            tag_q        <= tag_d;
            req_tag_q    <= req_tag_d;
            req_idx_q    <= req_idx_d;
            req_word_q   <= req_word_d;
            beat_q       <= beat_d;
            flush_pend_q <= flush_pend_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    // Data array is qualified by the valid bits, so it is never reset.
    always_ff @(posedge clk) begin
        if (dat_we) data_q[req_idx_q][beat_q] <= mem_rdata;
    end

endmodule

// File: tb/tb_icache_dm.sv
// Randomized bench for icache_dm against an array-based cache and memory model.
// Latency: checks hit at 1 cycle, miss at refill cycles + 2.
// Backpressure: memory responder inserts random mem_ready gaps and checks request stability.
module tb_icache_dm;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LINES  = 16;
    localparam int WORDS  = 4;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              cpu_valid;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_ready;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    logic              flush;
    logic [CNT_W-1:0]  hit_count;
    logic [CNT_W-1:0]  miss_count;

    always #5 clk = ~clk;

    icache_dm #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINES(LINES), .WORDS(WORDS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_ready(cpu_ready),
        .resp_valid(resp_valid), .resp_data(resp_data), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .flush(flush),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // backing memory: 2 KB, addresses 0..0x7FF
    logic [31:0] mem [512];

    // reference cache state
    bit m_valid [LINES];
    int m_tag   [LINES];
    int exp_hits = 0;
    int exp_miss = 0;

    function automatic int f_idx(input logic [31:0] a);
        return int'((a / (WORDS * 4)) % LINES);
    endfunction
    function automatic int f_tag(input logic [31:0] a);
        return int'(a / (WORDS * 4 * LINES));
    endfunction
    function automatic int sat(input int x);
        return (x > CMAX) ? CMAX : x;
    endfunction
    task automatic model_clear();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    endtask

    // memory responder
    int          gap_max = 0;
    int          gap_left = 0;
    int          req_cycles = 0;
    logic [31:0] beat_q [$];
    bit          prev_wait = 1'b0;
    logic [31:0] prev_addr = '0;

    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                req_cycles++;
                chk("rdy_in_refill", {63'd0, cpu_ready}, 64'd0);
                if (prev_wait) chk("addr_stable", mem_addr, prev_addr);
                if (gap_left == 0) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem[mem_addr[10:2]];
                    beat_q.push_back(mem_addr);
                    gap_left  = $urandom_range(0, gap_max);
                    prev_wait = 1'b0;
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = $urandom;
                    gap_left--;
                    prev_wait = 1'b1;
                    prev_addr = mem_addr;
                end
            end else begin
                mem_ready = 1'b0;
                prev_wait = 1'b0;
            end
        end
    end

    // One fetch; fl_at > 0 pulses flush that many cycles after accept when a miss is expected.
    task automatic fetch(input logic [31:0] a, input int fl_at);
        int          idx, tg, lat, waitc;
        bit          hit;
        logic [31:0] base;
        idx  = f_idx(a);
        tg   = f_tag(a);
        base = a & ~32'(WORDS * 4 - 1);
        beat_q.delete();
        @(negedge clk);
        cpu_valid = 1'b1;
        cpu_addr  = a;
        #1;
        waitc = 0;
        while (!cpu_ready && waitc < 50) begin
            @(negedge clk);
            #1;
            waitc++;
        end
        if (!cpu_ready) begin
            chk("accept_timeout", 64'd0, 64'd1);
            cpu_valid = 1'b0;
            return;
        end
        hit = m_valid[idx] && (m_tag[idx] == tg);
        req_cycles = 0;
        @(negedge clk);
        cpu_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 300) begin
            flush = (lat == fl_at) && !hit;
            @(negedge clk);
            lat++;
        end
        flush = 1'b0;
        #1;
        chk("resp_seen", {63'd0, resp_valid}, 64'd1);
        chk("resp_data", resp_data, mem[a[10:2]]);
        if (hit) begin
            chk("hit_lat", lat, 1);
            exp_hits = sat(exp_hits + 1);
        end else begin
            chk("miss_lat", lat, req_cycles + 2);
            chk("beat_cnt", beat_q.size(), WORDS);
            for (int i = 0; i < WORDS && i < beat_q.size(); i++)
                chk("beat_addr", beat_q[i], base + 32'(4 * i));
            exp_miss     = sat(exp_miss + 1);
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            if (fl_at > 0) begin
                chk("pend_rdy", {63'd0, cpu_ready}, 64'd0);
                model_clear();
            end
        end
        chk("hit_count", hit_count, exp_hits);
        chk("miss_count", miss_count, exp_miss);
        @(negedge clk);
        chk("resp_pulse", {63'd0, resp_valid}, 64'd0);
    endtask

    // Three back-to-back hits starting at a0 (line must already be cached).
    task automatic burst(input logic [31:0] a0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk("b2b_vld", {63'd0, resp_valid}, 64'd1);
                chk("b2b_dat", resp_data, mem[int'(a0 >> 2) + i - 1]);
            end
            if (i < 3) begin
                cpu_valid = 1'b1;
                cpu_addr  = a0 + 32'(4 * i);
                #1;
                chk("b2b_rdy", {63'd0, cpu_ready}, 64'd1);
            end else begin
                cpu_valid = 1'b0;
            end
        end
        exp_hits = sat(exp_hits + 3);
        chk("b2b_hits", hit_count, exp_hits);
    endtask

    // Flush in IDLE together with a request: request must be refused.
    task automatic idle_flush(input logic [31:0] a);
        @(negedge clk);
        cpu_valid = 1'b1;
        cpu_addr  = a;
        flush     = 1'b1;
        #1;
        chk("flush_rdy", {63'd0, cpu_ready}, 64'd0);
        @(negedge clk);
        cpu_valid = 1'b0;
        flush     = 1'b0;
        chk("flush_noresp", {63'd0, resp_valid}, 64'd0);
        model_clear();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rdy"}, {63'd0, cpu_ready}, 64'd0);
        chk({tag, "_rv"}, {63'd0, resp_valid}, 64'd0);
        chk({tag, "_rd"}, resp_data, 64'd0);
        chk({tag, "_mreq"}, {63'd0, mem_req}, 64'd0);
        chk({tag, "_maddr"}, mem_addr, 64'd0);
        chk({tag, "_hc"}, hit_count, 64'd0);
        chk({tag, "_mc"}, miss_count, 64'd0);
    endtask

    // Reset asserted while beat 2 of a refill is on the bus.
    task automatic reset_mid_refill(input logic [31:0] a);
        logic [31:0] base;
        int          waitc;
        base = a & ~32'(WORDS * 4 - 1);
        gap_max = 0;
        @(negedge clk);
        cpu_valid = 1'b1;
        cpu_addr  = a;
        #1;
        chk("rst_t_rdy", {63'd0, cpu_ready}, 64'd1);
        @(negedge clk);
        cpu_valid = 1'b0;
        waitc = 0;
        while (!(mem_req && mem_addr == base + 32'd8) && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        chk("rst_t_beat2", {63'd0, mem_req}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        model_clear();
        exp_hits = 0;
        exp_miss = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          r;
        for (int i = 0; i < 512; i++) mem[i] = $urandom;
        for (int i = 0; i < 4; i++) begin
            mem[16 + i] = 32'hA0 + 32'(i);
            mem[80 + i] = 32'hB0 + 32'(i);
        end
        model_clear();
        rst       = 1'b1;
        cpu_valid = 1'b0;
        cpu_addr  = '0;
        flush     = 1'b0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // directed sequence
        fetch(32'h40, 0);
        chk("first_data", resp_data, 64'hA0);
        burst(32'h44);
        fetch(32'h140, 0);
        fetch(32'h40, 0);
        gap_max = 3;
        fetch(32'h1C8, 0);
        fetch(32'h2F4, 0);
        gap_max = 0;
        fetch(32'h80, 2);
        fetch(32'h80, 0);
        fetch(32'h84, 0);
        idle_flush(32'h84);
        fetch(32'h88, 0);
        idle_flush(32'h80);
        reset_mid_refill(32'h80);
        fetch(32'h80, 0);

        // randomized traffic
        for (int n = 0; n < 200; n++) begin
            gap_max = $urandom_range(0, 3);
            r = $urandom_range(0, 19);
            if ($urandom_range(0, 3) != 0) a = 32'($urandom_range(0, 511));
            else                           a = 32'($urandom_range(0, 2047));
            if (r == 0)      idle_flush(a);
            else if (r < 3)  fetch(a, $urandom_range(1, 5));
            else             fetch(a, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Parametrised direct-mapped instruction cache; successor to the flat register-file instruction store.
- Sits between the fetch stage (CPU port, valid/ready request plus registered response) and backing instruction memory (word-per-beat refill port).
- Adds tags, valid bits, multi-word lines, miss detection, a refill state machine, global flush and hit/miss counters.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, instruction word width; 4 bytes per word is fixed.
- LINES, 16, number of cache lines; power of two, 2 or more.
- WORDS, 4, words per line; power of two, 2 or more.
- CNT_W, 16, width of the hit and miss counters.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cpu_valid  in  1  fetch request present.
- cpu_addr  in  ADDR_W  fetch byte address; bits [1:0] are ignored.
- cpu_ready  out  1  request accepted this cycle when cpu_valid is also high.
- resp_valid  out  1  one-cycle pulse; resp_data is valid.
- resp_data  out  DATA_W  fetched instruction.
- mem_req  out  1  refill beat request.
- mem_addr  out  ADDR_W  word-aligned refill address.
- mem_ready  in  1  mem_rdata valid; beat complete.
- mem_rdata  in  DATA_W  refill data.
- flush  in  1  invalidate all lines.
- hit_count  out  CNT_W  saturating count of hits.
- miss_count  out  CNT_W  saturating count of misses.

Behaviour:
- Address split:
  - OFF = log2(WORDS) + 2.
  - word = addr[OFF-1:2].
  - index = addr[OFF+log2(LINES)-1:OFF].
  - tag = the remaining upper bits.
- Storage:
  - Per line: valid bit, tag, WORDS data words.
  - Only valid bits, tags and counters require reset; the data array need not be reset.
- Reset (async, rst=1):
  - State=IDLE; all valid bits=0; counters=0.
  - cpu_ready=0 while rst is high.
  - resp_valid=0, resp_data=0, mem_req=0, mem_addr=0.
  - Reset mid-refill abandons the refill; the line stays invalid.
- IDLE:
  - cpu_ready=1 unless flush or a pending flush is present.
  - On accept, hit = valid[index] && tag match:
    - Next cycle resp_valid=1 and resp_data=line word; hit_count++; stay IDLE.
    - Back-to-back hits give one response per cycle.
  - On accept with a miss: latch the address, miss_count++, beat=0, go to REFILL.
- REFILL:
  - cpu_ready=0.
  - mem_req=1 with mem_addr = {tag, index, beat, 2'b00}; mem_addr is stable until mem_ready.
  - On mem_ready: store mem_rdata at the beat slot, beat++.
  - On the last beat (beat=WORDS-1): write tag, set valid, go to RESPOND. mem_req drops the following cycle.
  - Refill always starts at word 0; there is no critical-word-first.
- RESPOND:
  - One cycle: resp_valid=1 with the requested word, taken from the just-filled line.
  - cpu_ready=0; return to IDLE.
- Response latency:
  - Hit: 1 cycle after accept.
  - Miss: WORDS mem_ready beats plus 2 cycles minimum.
- Flush:
  - In IDLE, flush=1 clears every valid bit at the next edge.
  - cpu_ready=0 that cycle, so the request is not accepted; flush wins over a simultaneous request.
  - Flush in REFILL or RESPOND sets flush_pending. It is applied on the first IDLE cycle, before any new request is accepted, and clears the line just filled.
- Counters:
  - Saturate at all ones; no wrap.
  - A miss counts once, not again when RESPOND completes.
- Conflict: a miss to a valid line with a different tag overwrites the line (eviction).
- No writes from the CPU side. Only one outstanding miss; there is no hit-under-miss.

Test Plan (LINES=16, WORDS=4):
- Reset, fetch 0x40 -> miss; mem_addr sequence 0x40, 0x44, 0x48, 0x4C, returning 0xA0..0xA3 -> resp_data=0xA0; miss_count=1.
- After the previous test, fetch 0x44, 0x48, 0x4C on consecutive cycles -> three consecutive resp_valid cycles, data 0xA1, 0xA2, 0xA3; hit_count=3.
- Fetch 0x140 (index 4, tag 1) -> miss; refill 0xB0..0xB3, resp=0xB0. Then fetch 0x40 -> miss again (eviction).
- Insert mem_ready gaps of 0-3 cycles -> mem_req and mem_addr held stable; response still correct; cpu_ready=0 throughout.
- Flush during a refill of 0x80, then fetch 0x80 -> flush applied after RESPOND; second fetch misses; miss_count increments by 2.
- Assert rst during beat 2 of a refill -> all outputs 0 immediately; a later fetch of the same address misses with beat restarting at 0.
